hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter AW, default 5, meaning register address width (32 registers).
REQ-002 SHALL have parameter CW, default 16, meaning stall counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports RA_id, RB_id  input  AW  source register addresses of the instruction in decode.
REQ-006 SHALL have port RW_id  input  AW  destination register address of the instruction in decode.
REQ-007 SHALL have ports valid_id, wr_id, load_id  input  1 each  instruction valid, writes a register, is a load.
REQ-008 SHALL have port flush  input  1  discard the instructions in the OF and EX slots (taken branch).
REQ-009 SHALL have ports mux_sel_A, mux_sel_B  output  2 each  operand source: 00 bank, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-010 SHALL have port stall  output  1  holds decode and inserts a bubble into EX.
REQ-011 SHALL have ports RW_dm  output  AW, and wr_dm  output  1  destination and write qualifier of the instruction in DM, for the register bank.
REQ-012 SHALL have port stall_cnt  output  CW  count of stall cycles.

Function
REQ-013 SHALL track four slots, OF, EX, DM and WB, each holding {valid, wr, load, RA, RB, RW}.
REQ-014 On each rising edge with stall=0: OF <- decode inputs; EX <- OF; DM <- EX; WB <- DM.
REQ-015 On a rising edge with stall=1: OF holds; EX <- bubble (valid=0); DM <- EX; WB <- DM.
REQ-016 A slot is a producer only when valid=1 and wr=1.
REQ-017 mux_sel_X is combinational from OF.RX: 01 if EX produces RX; else 10 if DM does; else 11 if WB does; else 00.
REQ-018 The priority is EX > DM > WB, so the youngest producer wins on multiple matches.
REQ-019 Register address 0 SHALL be forwarded like any other address.
REQ-020 stall SHALL be 1 exactly when OF.valid, EX.valid, EX.wr and EX.load are all 1 and EX.RW equals OF.RA or OF.RB.
REQ-021 While stall=1, mux_sel_A and mux_sel_B SHALL be forced to 00.
REQ-022 After a one-cycle stall, the load sits in DM and the dependent operand selects 10.
REQ-023 flush=1 at an edge SHALL write valid=0 into OF and EX; DM and WB still advance.
REQ-024 flush SHALL override stall.
REQ-025 If OF.valid=0, stall=0 and both selects are 00.
REQ-026 RW_dm and wr_dm SHALL be driven from DM.RW and from DM.valid&DM.wr.
REQ-027 stall_cnt SHALL increment at each edge where stall=1 and flush=0, and SHALL saturate at all ones (no wrap).

Reset
REQ-028 rst_n low SHALL immediately clear all slot valid bits and zero all slot fields.
REQ-029 While rst_n is low: mux_sel_A=00, mux_sel_B=00, stall=0, RW_dm=0, wr_dm=0, stall_cnt=0.
REQ-030 Reset asserted mid-stall SHALL abandon the stall; the first post-reset edge loads OF only.

Structure
REQ-031 A shared package SHALL hold the slot struct typedef, the select encoding constants SEL_BANK/SEL_EX/SEL_DM/SEL_WB, and AW.
REQ-032 A sub-module operand_select SHALL perform the address compare and priority encode, and SHALL be instanced twice (A and B).

Verification
REQ-033 Bench SHALL check: ADD R3 followed by SUB using R3 as RA -> mux_sel_A=01 in the consumer's OF cycle.
REQ-034 Bench SHALL check: producers of R5 two and three slots ahead, consumer RB=R5 -> mux_sel_B=10 (youngest wins).
REQ-035 Bench SHALL check: LOAD R7 then ADD R7,R7 -> stall=1 for one cycle, selects 00 during it, then mux_sel_A=mux_sel_B=10, stall_cnt=1.
REQ-036 Bench SHALL check: producer of R2, two bubbles, consumer RA=R2 -> mux_sel_A=11; with three bubbles -> 00.
REQ-037 Bench SHALL check: flush asserted during a load-use stall -> stall drops next cycle, OF/EX invalid, stall_cnt unchanged.
REQ-038 Bench SHALL check: rst_n pulsed low mid-stall, and 2^CW+3 consecutive stalls -> outputs zero immediately, and stall_cnt saturates at all ones.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit: pipeline slot record and
// operand-select encoding.
package hazard_forward_unit_pkg;

  localparam int unsigned AW = 5;

  typedef enum logic [1:0] {
    SEL_BANK = 2'b00,
    SEL_EX   = 2'b01,
    SEL_DM   = 2'b10,
    SEL_WB   = 2'b11
  } sel_e;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic          load;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rw;
  } slot_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side inputs and forwarding/stall outputs of the hazard unit.
interface hazard_forward_unit_if #(
  parameter int unsigned AW = hazard_forward_unit_pkg::AW,
  parameter int unsigned CW = 16
);

  logic [AW-1:0] RA_id;
  logic [AW-1:0] RB_id;
  logic [AW-1:0] RW_id;
  logic          valid_id;
  logic          wr_id;
  logic          load_id;
  logic          flush;
  logic [1:0]    mux_sel_A;
  logic [1:0]    mux_sel_B;
  logic          stall;
  logic [AW-1:0] RW_dm;
  logic          wr_dm;
  logic [CW-1:0] stall_cnt;

  modport master (
    output RA_id, RB_id, RW_id, valid_id, wr_id, load_id, flush,
    input  mux_sel_A, mux_sel_B, stall, RW_dm, wr_dm, stall_cnt
  );

  modport slave (
    input  RA_id, RB_id, RW_id, valid_id, wr_id, load_id, flush,
    output mux_sel_A, mux_sel_B, stall, RW_dm, wr_dm, stall_cnt
  );

endinterface

// File: rtl/hazard_forward_unit_operand_select.sv
// Picks the operand source for one OF source register: youngest producer
// among EX, DM, WB wins; register bank otherwise.
module operand_select
  import hazard_forward_unit_pkg::*;
(
  input  logic [AW-1:0] src,
  input  logic          of_valid,
  input  logic          stall,
  input  logic          ex_prod,
  input  logic [AW-1:0] ex_rw,
  input  logic          dm_prod,
  input  logic [AW-1:0] dm_rw,
  input  logic          wb_prod,
  input  logic [AW-1:0] wb_rw,
  output logic [1:0]    sel
);

  always_comb begin
    sel = SEL_BANK;
    if (of_valid && !stall) begin
      if (ex_prod && (ex_rw == src)) begin
        sel = SEL_EX;
      end else if (dm_prod && (dm_rw == src)) begin
        sel = SEL_DM;
      end else if (wb_prod && (wb_rw == src)) begin
        sel = SEL_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Four-slot (OF/EX/DM/WB) pipeline tracker producing operand forwarding
// selects, load-use stall, and a saturating stall counter.
module hazard_forward_unit #(
  parameter int unsigned AW = hazard_forward_unit_pkg::AW,
  parameter int unsigned CW = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_unit_if.slave bus
);

  import hazard_forward_unit_pkg::*;

  slot_t         of_q, ex_q, dm_q, wb_q;
  slot_t         of_d, ex_d, dm_d, wb_d;
  slot_t         dec;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [AW-1:0] ra_id, rb_id, rw_id;
  logic          stall;
  logic          ex_prod, dm_prod, wb_prod;
  logic [1:0]    sel_a, sel_b;
  logic          unused_wb_fields;

  assign ra_id = bus.RA_id;
  assign rb_id = bus.RB_id;
  assign rw_id = bus.RW_id;

  always_comb begin
    dec       = '0;
    dec.valid = bus.valid_id;
    dec.wr    = bus.wr_id;
    dec.load  = bus.load_id;
    dec.ra    = ra_id;
    dec.rb    = rb_id;
    dec.rw    = rw_id;
  end

  // Load in EX whose result OF needs cannot be forwarded until it reaches DM.
  assign stall = of_q.valid && ex_q.valid && ex_q.wr && ex_q.load &&
                 ((ex_q.rw == of_q.ra) || (ex_q.rw == of_q.rb));

  assign ex_prod = ex_q.valid && ex_q.wr;
  assign dm_prod = dm_q.valid && dm_q.wr;
  assign wb_prod = wb_q.valid && wb_q.wr;

  // DM and WB always advance; flush takes precedence over the stall hold.
  always_comb begin
    of_d        = dec;
    ex_d        = of_q;
    dm_d        = ex_q;
    wb_d        = dm_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      of_d = '0;
      ex_d = '0;
    end else if (stall) begin
      of_d = of_q;
      ex_d = '0;
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_q        <= '0;
      ex_q        <= '0;
      dm_q        <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      of_q        <= of_d;
      ex_q        <= ex_d;
      dm_q        <= dm_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  operand_select u_sel_a (
    .src      (of_q.ra),
    .of_valid (of_q.valid),
    .stall    (stall),
    .ex_prod  (ex_prod),
    .ex_rw    (ex_q.rw),
    .dm_prod  (dm_prod),
    .dm_rw    (dm_q.rw),
    .wb_prod  (wb_prod),
    .wb_rw    (wb_q.rw),
    .sel      (sel_a)
  );

  operand_select u_sel_b (
    .src      (of_q.rb),
    .of_valid (of_q.valid),
    .stall    (stall),
    .ex_prod  (ex_prod),
    .ex_rw    (ex_q.rw),
    .dm_prod  (dm_prod),
    .dm_rw    (dm_q.rw),
    .wb_prod  (wb_prod),
    .wb_rw    (wb_q.rw),
    .sel      (sel_b)
  );

  // WB sources and load flag are retired with the slot; nothing reads them.
  assign unused_wb_fields = ^{wb_q.load, wb_q.ra, wb_q.rb};

  assign bus.mux_sel_A = sel_a;
  assign bus.mux_sel_B = sel_b;
  assign bus.stall     = stall;
  assign bus.RW_dm     = dm_q.rw;
  assign bus.wr_dm     = dm_prod;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed hazard scenarios plus
// random instruction streams against an instruction-level reference model.
module tb_hazard_forward_unit;

  localparam int AW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    bit valid;
    bit wr;
    bit load;
    int ra;
    int rb;
    int rw;
  } ins_t;

  typedef struct {
    string tag;
    int    sa;
    int    sb;
    int    st;
    int    rwdm;
    int    wrdm;
    int    cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  hazard_forward_unit_if #(.AW(AW), .CW(CW)) bus ();

  hazard_forward_unit #(.AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference state: pipe[0]=OF, pipe[1]=EX, pipe[2]=DM, pipe[3]=WB.
  ins_t  pipe[4];
  int    cnt_m;
  exp_t  sb[$];
  string cur_tag;
  int    vectors;
  int    miscompares;
  event  ev_sample;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t mk(bit v, bit w, bit l, int ra, int rb, int rw);
    ins_t r;
    r.valid = v; r.wr = w; r.load = l;
    r.ra = ra; r.rb = rb; r.rw = rw;
    return r;
  endfunction

  function automatic ins_t empty_ins();
    return mk(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit model_stall();
    return pipe[0].valid && pipe[1].valid && pipe[1].wr && pipe[1].load &&
           (pipe[1].rw == pipe[0].ra || pipe[1].rw == pipe[0].rb);
  endfunction

  // Selector value equals the pipeline distance of the youngest producer.
  function automatic int model_sel(int a);
    if (!pipe[0].valid || model_stall()) return 0;
    for (int k = 1; k <= 3; k++)
      if (pipe[k].valid && pipe[k].wr && pipe[k].rw == a) return k;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) pipe[k] = empty_ins();
    cnt_m = 0;
  endtask

  task automatic model_edge(input ins_t d, input bit fl);
    bit st;
    if (!rst_n) begin
      model_clear();
      return;
    end
    st = model_stall();
    if (!fl && st && cnt_m < CNT_MAX) cnt_m = cnt_m + 1;
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    if (fl) begin
      pipe[1] = empty_ins();
      pipe[0] = empty_ins();
    end else if (st) begin
      pipe[1] = empty_ins();
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = d;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.tag  = cur_tag;
    e.sa   = model_sel(pipe[0].ra);
    e.sb   = model_sel(pipe[0].rb);
    e.st   = int'(model_stall());
    e.rwdm = pipe[2].rw;
    e.wrdm = int'(pipe[2].valid && pipe[2].wr);
    e.cnt  = cnt_m;
    sb.push_back(e);
  endtask

  task automatic step(input ins_t d, input bit fl);
    bus.RA_id    = AW'(d.ra);
    bus.RB_id    = AW'(d.rb);
    bus.RW_id    = AW'(d.rw);
    bus.valid_id = d.valid;
    bus.wr_id    = d.wr;
    bus.load_id  = d.load;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    model_edge(d, fl);
    push_expect();
  endtask

  // Assert reset away from any edge and sample before the next clock edge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    cur_tag = "reset";
    push_expect();
    -> ev_sample;
    repeat (cycles) step(empty_ins(), 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input string what, input int act, input int exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", tag, what, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or ev_sample);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk(e.tag, "mux_sel_A", int'(bus.mux_sel_A), e.sa);
        chk(e.tag, "mux_sel_B", int'(bus.mux_sel_B), e.sb);
        chk(e.tag, "stall",     int'(bus.stall),     e.st);
        chk(e.tag, "RW_dm",     int'(bus.RW_dm),     e.rwdm);
        chk(e.tag, "wr_dm",     int'(bus.wr_dm),     e.wrdm);
        chk(e.tag, "stall_cnt", int'(bus.stall_cnt), e.cnt);
      end
    end
  end

  initial begin : stimulus
    ins_t nop;
    ins_t d;
    nop          = empty_ins();
    vectors      = 0;
    miscompares  = 0;
    cur_tag      = "init";
    rst_n        = 1'b1;
    bus.RA_id    = '0;
    bus.RB_id    = '0;
    bus.RW_id    = '0;
    bus.valid_id = 1'b0;
    bus.wr_id    = 1'b0;
    bus.load_id  = 1'b0;
    bus.flush    = 1'b0;
    model_clear();
    do_reset(2);

    cur_tag = "add_sub_ex_fwd";
    step(mk(1, 1, 0, 1, 2, 3), 1'b0);
    step(mk(1, 1, 0, 3, 4, 6), 1'b0);
    repeat (3) step(nop, 1'b0);

    cur_tag = "youngest_dm_wins";
    step(mk(1, 1, 0, 0, 0, 5), 1'b0);
    step(mk(1, 1, 0, 1, 1, 5), 1'b0);
    step(mk(1, 0, 0, 2, 2, 9), 1'b0);
    step(mk(1, 1, 0, 4, 5, 10), 1'b0);
    repeat (3) step(nop, 1'b0);

    cur_tag = "load_use";
    do_reset(1);
    step(mk(1, 1, 1, 0, 0, 7), 1'b0);
    step(mk(1, 1, 0, 7, 7, 8), 1'b0);
    step(nop, 1'b0);
    repeat (3) step(nop, 1'b0);

    cur_tag = "wb_fwd_2bubbles";
    step(mk(1, 1, 0, 0, 1, 2), 1'b0);
    repeat (2) step(nop, 1'b0);
    step(mk(1, 1, 0, 2, 3, 4), 1'b0);
    cur_tag = "bank_3bubbles";
    step(mk(1, 1, 0, 0, 1, 2), 1'b0);
    repeat (3) step(nop, 1'b0);
    step(mk(1, 1, 0, 2, 3, 4), 1'b0);
    repeat (3) step(nop, 1'b0);

    cur_tag = "flush_in_stall";
    step(mk(1, 1, 1, 0, 0, 7), 1'b0);
    step(mk(1, 1, 0, 1, 7, 8), 1'b0);
    step(mk(1, 1, 0, 7, 7, 9), 1'b1);
    repeat (3) step(nop, 1'b0);

    cur_tag = "reset_mid_stall";
    step(mk(1, 1, 1, 0, 0, 7), 1'b0);
    step(mk(1, 1, 0, 7, 1, 8), 1'b0);
    do_reset(1);
    cur_tag = "post_reset";
    step(mk(1, 1, 0, 1, 2, 3), 1'b0);
    step(mk(1, 1, 0, 3, 3, 6), 1'b0);
    repeat (3) step(nop, 1'b0);

    cur_tag = "stall_cnt_saturate";
    do_reset(1);
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      step(mk(1, 1, 1, 0, 0, 12), 1'b0);
      step(mk(1, 1, 0, 12, 1, 13), 1'b0);
      step(nop, 1'b0);
    end
    repeat (3) step(nop, 1'b0);

    cur_tag = "random";
    for (int i = 0; i < 500; i++) begin
      d = mk($urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step(d, $urandom_range(0, 99) < 8);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
